// File: rtl/unit_pkg.sv
// Shared encodings and per-type stat tables for the battlefield unit.
package unit_pkg;

  localparam logic [4:0] S_I  = 5'b00001;
  localparam logic [4:0] S_D1 = 5'b00010;
  localparam logic [4:0] S_D2 = 5'b00100;
  localparam logic [4:0] S_D3 = 5'b01000;
  localparam logic [4:0] S_A  = 5'b10000;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_1    = 2'd1;
  localparam logic [1:0] T_2    = 2'd2;
  localparam logic [1:0] T_3    = 2'd3;

  localparam logic [8:0] START_POS = 9'd511;

  localparam logic [7:0] HP1 = 8'd200;
  localparam logic [7:0] HP2 = 8'd120;
  localparam logic [7:0] HP3 = 8'd250;
  localparam logic [8:0] SPD1 = 9'd4;
  localparam logic [8:0] SPD2 = 9'd2;
  localparam logic [8:0] SPD3 = 9'd1;
  localparam logic [7:0] DMG1 = 8'd10;
  localparam logic [7:0] DMG2 = 8'd25;
  localparam logic [7:0] DMG3 = 8'd40;

  typedef struct packed {
    logic [7:0] hp;
    logic [8:0] spd;
    logic [7:0] dmg;
  } stats_t;

endpackage

// File: rtl/unit_if.sv
// Controller <-> unit signal bundle.
interface unit_if;
  logic       moveSCEN;
  logic       damageSCEN;
  logic [7:0] damageIn;
  logic       SW1;
  logic       SW2;
  logic       SW3;
  logic       purchase;
  logic [8:0] enemyFront;
  logic [8:0] position;
  logic [7:0] damageOut;
  logic [1:0] unitType;
  logic       q_I;
  logic       q_Deploy1;
  logic       q_Deploy2;
  logic       q_Deploy3;
  logic       q_Alive;
  logic [7:0] health;

  modport master (
    output moveSCEN, damageSCEN, damageIn,
    output SW1, SW2, SW3, purchase, enemyFront,
    input  position, damageOut, unitType, health,
    input  q_I, q_Deploy1, q_Deploy2, q_Deploy3, q_Alive
  );

  modport slave (
    input  moveSCEN, damageSCEN, damageIn,
    input  SW1, SW2, SW3, purchase, enemyFront,
    output position, damageOut, unitType, health,
    output q_I, q_Deploy1, q_Deploy2, q_Deploy3, q_Alive
  );
endinterface

// File: rtl/unit_stats_lut.sv
// Unit type -> {hp, speed, damage} lookup.
import unit_pkg::*;

module unit_stats_lut (
  input  logic [1:0] i_type,
  output stats_t     o_stats
);
  always_comb begin
    o_stats = '0;
    unique case (i_type)
      T_1:     o_stats = '{hp: HP1, spd: SPD1, dmg: DMG1};
      T_2:     o_stats = '{hp: HP2, spd: SPD2, dmg: DMG2};
      T_3:     o_stats = '{hp: HP3, spd: SPD3, dmg: DMG3};
      default: o_stats = '0;
    endcase
  end
endmodule

// File: rtl/unit.sv
// One purchasable combat unit: buy, deploy, march, take damage, die.
import unit_pkg::*;

module unit (
  input logic clk,
  input logic reset,
  unit_if.slave bus
);
  logic [4:0] r_state;
  logic [8:0] r_pos;
  logic [7:0] r_hp;
  logic [1:0] r_type;

  logic [1:0] w_lut_type;
  stats_t     w_st;
  logic       w_alive;
  logic [8:0] w_tgt;
  logic [9:0] w_ef1;
  logic       w_kill;

  // While deploying, the LUT serves the incoming type's starting stats.
  always_comb begin
    w_lut_type = r_type;
    unique case (1'b1)
      r_state[1]: w_lut_type = T_1;
      r_state[2]: w_lut_type = T_2;
      r_state[3]: w_lut_type = T_3;
      default:    w_lut_type = r_type;
    endcase
  end

  unit_stats_lut u_lut (
    .i_type  (w_lut_type),
    .o_stats (w_st)
  );

  assign w_alive = r_state[4];
  assign w_tgt   = (r_pos > w_st.spd) ? r_pos - w_st.spd : 9'd0;
  assign w_ef1   = {1'b0, bus.enemyFront} + 10'd1;
  assign w_kill  = bus.damageIn >= r_hp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_I;
      r_pos   <= START_POS;
      r_hp    <= 8'd0;
      r_type  <= T_NONE;
    end else begin
      unique case (1'b1)
        r_state[0]: begin
          if (bus.purchase) begin
            if (bus.SW1)      r_state <= S_D1;
            else if (bus.SW2) r_state <= S_D2;
            else if (bus.SW3) r_state <= S_D3;
          end
        end
        r_state[1], r_state[2], r_state[3]: begin
          r_state <= S_A;
          r_type  <= w_lut_type;
          r_hp    <= w_st.hp;
          r_pos   <= START_POS;
        end
        r_state[4]: begin
          if (bus.damageSCEN && w_kill) begin
            r_state <= S_I;
            r_hp    <= 8'd0;
            r_type  <= T_NONE;
            r_pos   <= START_POS;
          end else begin
            if (bus.damageSCEN)
              r_hp <= r_hp - bus.damageIn;
            if (bus.moveSCEN) begin
              if (w_tgt > bus.enemyFront)
                r_pos <= w_tgt;
              else if ({1'b0, r_pos} > w_ef1)
                r_pos <= w_ef1[8:0];
            end
          end
        end
        default: r_state <= S_I;
      endcase
    end
  end

  assign bus.position  = r_pos;
  assign bus.health    = r_hp;
  assign bus.unitType  = r_type;
  assign bus.damageOut = w_alive ? w_st.dmg : 8'd0;
  assign bus.q_I       = r_state[0];
  assign bus.q_Deploy1 = r_state[1];
  assign bus.q_Deploy2 = r_state[2];
  assign bus.q_Deploy3 = r_state[3];
  assign bus.q_Alive   = r_state[4];
endmodule

// File: tb/tb_unit.sv
// Vector table plus a marching sequence, checked through an expected-value queue.
module tb_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;

  unit_if u_if ();

  unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] st;
    logic [1:0] ty;
    logic [8:0] pos;
    logic [7:0] hp;
    logic [7:0] dout;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       pur;
    logic [2:0] sw;
    logic       mv;
    logic       dm;
    logic [7:0] din;
    logic [8:0] ef;
    exp_t       e;
  } vec_t;

  localparam logic [4:0] I  = 5'b00001;
  localparam logic [4:0] D1 = 5'b00010;
  localparam logic [4:0] D2 = 5'b00100;
  localparam logic [4:0] D3 = 5'b01000;
  localparam logic [4:0] A  = 5'b10000;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  vec_t vt[21];

  task automatic check(input string nm);
    exp_t e;
    exp_t a;
    e = q.pop_front();
    a.st = {u_if.q_Alive, u_if.q_Deploy3, u_if.q_Deploy2,
            u_if.q_Deploy1, u_if.q_I};
    a.ty = u_if.unitType;
    a.pos = u_if.position;
    a.hp = u_if.health;
    a.dout = u_if.damageOut;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got st=%b ty=%0d pos=%0d hp=%0d dmg=%0d want st=%b ty=%0d pos=%0d hp=%0d dmg=%0d",
        nm, a.st, a.ty, a.pos, a.hp, a.dout,
        e.st, e.ty, e.pos, e.hp, e.dout);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst;
    u_if.purchase = v.pur;
    u_if.SW1 = v.sw[0];
    u_if.SW2 = v.sw[1];
    u_if.SW3 = v.sw[2];
    u_if.moveSCEN = v.mv;
    u_if.damageSCEN = v.dm;
    u_if.damageIn = v.din;
    u_if.enemyFront = v.ef;
    q.push_back(v.e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  function automatic vec_t mk(input logic rst, input logic pur,
      input logic [2:0] sw, input logic mv, input logic dm,
      input logic [7:0] din, input logic [8:0] ef,
      input logic [4:0] st, input logic [1:0] ty,
      input logic [8:0] pos, input logic [7:0] hp,
      input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.pur = pur; v.sw = sw;
    v.mv = mv; v.dm = dm; v.din = din; v.ef = ef;
    v.e.st = st; v.e.ty = ty; v.e.pos = pos;
    v.e.hp = hp; v.e.dout = dout;
    return v;
  endfunction

  initial begin
    int m;
    int tgt;
    vec_t v;
    //        rst pur sw     mv dm din  ef     st ty pos  hp   dmg
    vt[0]  = mk(1, 0, 3'b000, 0, 0, 0,   0,   I,  0, 511, 0,   0);
    vt[1]  = mk(0, 1, 3'b001, 0, 0, 0,   0,   D1, 0, 511, 0,   0);
    vt[2]  = mk(0, 0, 3'b000, 0, 0, 0,   0,   A,  1, 511, 200, 10);
    vt[3]  = mk(0, 0, 3'b000, 1, 0, 0,   0,   A,  1, 507, 200, 10);
    vt[4]  = mk(0, 0, 3'b000, 1, 0, 0,   505, A,  1, 506, 200, 10);
    vt[5]  = mk(0, 0, 3'b000, 1, 0, 0,   505, A,  1, 506, 200, 10);
    vt[6]  = mk(0, 0, 3'b000, 0, 1, 128, 0,   A,  1, 506, 72,  10);
    vt[7]  = mk(0, 0, 3'b000, 1, 1, 128, 0,   I,  0, 511, 0,   0);
    vt[8]  = mk(0, 1, 3'b000, 0, 0, 0,   0,   I,  0, 511, 0,   0);
    vt[9]  = mk(0, 1, 3'b110, 0, 0, 0,   0,   D2, 0, 511, 0,   0);
    vt[10] = mk(0, 0, 3'b000, 0, 0, 0,   0,   A,  2, 511, 120, 25);
    vt[11] = mk(0, 0, 3'b000, 1, 0, 0,   0,   A,  2, 509, 120, 25);
    vt[12] = mk(0, 0, 3'b000, 1, 0, 0,   511, A,  2, 509, 120, 25);
    vt[13] = mk(0, 1, 3'b001, 0, 0, 0,   0,   A,  2, 509, 120, 25);
    vt[14] = mk(0, 0, 3'b000, 1, 1, 119, 0,   A,  2, 507, 1,   25);
    vt[15] = mk(1, 0, 3'b000, 0, 0, 0,   0,   I,  0, 511, 0,   0);
    vt[16] = mk(0, 1, 3'b100, 0, 0, 0,   0,   D3, 0, 511, 0,   0);
    vt[17] = mk(0, 0, 3'b000, 1, 1, 5,   0,   A,  3, 511, 250, 40);
    vt[18] = mk(0, 0, 3'b000, 1, 0, 0,   0,   A,  3, 510, 250, 40);
    vt[19] = mk(0, 0, 3'b000, 0, 1, 250, 0,   I,  0, 511, 0,   0);
    vt[20] = mk(0, 0, 3'b000, 1, 1, 50,  0,   I,  0, 511, 0,   0);

    u_if.purchase = 0; u_if.SW1 = 0; u_if.SW2 = 0; u_if.SW3 = 0;
    u_if.moveSCEN = 0; u_if.damageSCEN = 0;
    u_if.damageIn = 0; u_if.enemyFront = 0;

    for (int i = 0; i < 21; i++)
      step(vt[i], $sformatf("vec%0d", i));

    // March a type-1 unit all the way to an enemy at position 0.
    step(mk(1, 0, 3'b000, 0, 0, 0, 0, I, 0, 511, 0, 0), "mreset");
    step(mk(0, 1, 3'b001, 0, 0, 0, 0, D1, 0, 511, 0, 0), "mbuy");
    step(mk(0, 0, 3'b000, 0, 0, 0, 0, A, 1, 511, 200, 10), "mdeploy");
    m = 511;
    for (int k = 0; k < 130; k++) begin
      tgt = (m > 4) ? m - 4 : 0;
      if (tgt > 0) m = tgt;
      else if (m > 1) m = 1;
      v = mk(0, 0, 3'b000, 1, 0, 0, 0, A, 1, m[8:0], 200, 10);
      step(v, $sformatf("march%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
